even_parity_frame_rx: RTL and testbench

EVEN_PARITY_FRAME_RX -- requirements
Module: even_parity_frame_rx

---
 rtl/even_parity_frame_rx.sv | 95 +++++++++
 tb/tb_even_parity_frame_rx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/even_parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_W payload bits MSB first, even parity, stop bit.
// Reports payload, parity/framing errors and a saturating error count.
module even_parity_frame_rx #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              serial_in,
    input  logic              clear_cnt,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              busy
);

    localparam int BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state, state_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift;
    logic              par_bit;
    logic              done;
    logic              par_bad;
    logic              frame_bad;

    assign done      = in_valid && (state == STOP);
    assign par_bad   = ^{shift, par_bit};
    assign frame_bad = !serial_in;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (in_valid) begin
            case (state)
                IDLE:    if (!serial_in) state_next = DATA;
                DATA:    if (bit_cnt == BIT_W'(DATA_W - 1)) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            out_valid <= done;
            if (in_valid) begin
                case (state)
                    IDLE: bit_cnt <= '0;
                    DATA: begin
                        // truncating cast keeps the shift legal for DATA_W == 1
                        shift   <= DATA_W'({shift, serial_in});
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: par_bit <= serial_in;
                    STOP: begin
                        data_out   <= shift;
                        parity_err <= par_bad;
                        frame_err  <= frame_bad;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_count <= '0;
        else if (clear_cnt)
            err_count <= '0;
        else if (done && (par_bad || frame_bad) && (err_count != '1))
            err_count <= err_count + 1'b1;
    end

endmodule

// File: tb/tb_even_parity_frame_rx.sv
// Directed bench for even_parity_frame_rx with hand-computed expected values.
module tb_even_parity_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       serial_in;
    logic       clear_cnt;
    logic [2:0] data_out;
    logic       out_valid;
    logic       parity_err;
    logic       frame_err;
    logic [7:0] err_count;
    logic       busy;

    int vectors = 0;
    int errors  = 0;
    int pulses  = 0;

    even_parity_frame_rx #(.DATA_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .serial_in(serial_in),
        .clear_cnt(clear_cnt), .data_out(data_out), .out_valid(out_valid),
        .parity_err(parity_err), .frame_err(frame_err), .err_count(err_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge, tallying completed-frame pulses seen there.
    task automatic tick();
        @(negedge clk);
        if (out_valid === 1'b1) pulses++;
    endtask

    // Sends v[n-1] first; gap idle cycles follow every bit; clear_cnt rides with bit clr_idx.
    task automatic send_bits(input logic [11:0] v, input int n, input int gap, input int clr_idx);
        for (int i = n - 1; i >= 0; i--) begin
            tick();
            in_valid  = 1'b1;
            serial_in = v[i];
            clear_cnt = (i == clr_idx);
            for (int g = 0; g < gap; g++) begin
                tick();
                in_valid  = 1'b0;
                serial_in = 1'b1;
                clear_cnt = 1'b0;
            end
        end
        tick();
        in_valid  = 1'b0;
        serial_in = 1'b1;
        clear_cnt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; serial_in = 1'b1; clear_cnt = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        vectors++; if (data_out !== 3'b000) begin errors++; $display("FAIL reset_data got %b want 000", data_out); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL reset_errs got %b%b want 00", parity_err, frame_err); end
        vectors++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", err_count); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_good_frame();
        pulses = 0;
        send_bits(12'b010101, 6, 0, -1);
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL good_latency got %b want 1", out_valid); end
        vectors++; if (data_out !== 3'b101) begin errors++; $display("FAIL good_data got %b want 101", data_out); end
        vectors++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL good_errs got %b%b want 00", parity_err, frame_err); end
        vectors++; if (err_count !== 8'd0) begin errors++; $display("FAIL good_count got %0d want 0", err_count); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy got %b want 0", busy); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL good_pulse_width got %b want 0", out_valid); end
        vectors++; if (data_out !== 3'b101) begin errors++; $display("FAIL good_hold got %b want 101", data_out); end
    endtask

    task automatic test_parity_error();
        send_bits(12'b010001, 6, 0, -1);
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL par_valid got %b want 1", out_valid); end
        vectors++; if (data_out !== 3'b100) begin errors++; $display("FAIL par_data got %b want 100", data_out); end
        vectors++; if (parity_err !== 1'b1 || frame_err !== 1'b0) begin errors++; $display("FAIL par_errs got %b%b want 10", parity_err, frame_err); end
        vectors++; if (err_count !== 8'd1) begin errors++; $display("FAIL par_count got %0d want 1", err_count); end
    endtask

    task automatic test_frame_error();
        send_bits(12'b001100, 6, 0, -1);
        vectors++; if (data_out !== 3'b011) begin errors++; $display("FAIL frm_data got %b want 011", data_out); end
        vectors++; if (parity_err !== 1'b0 || frame_err !== 1'b1) begin errors++; $display("FAIL frm_errs got %b%b want 01", parity_err, frame_err); end
        vectors++; if (err_count !== 8'd2) begin errors++; $display("FAIL frm_count got %0d want 2", err_count); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL frm_idle got %b want 0", busy); end
    endtask

    task automatic test_gaps();
        pulses = 0;
        send_bits(12'b011001, 6, 3, -1);
        repeat (4) tick();
        vectors++; if (pulses !== 1) begin errors++; $display("FAIL gap_pulses got %0d want 1", pulses); end
        vectors++; if (data_out !== 3'b110) begin errors++; $display("FAIL gap_data got %b want 110", data_out); end
        vectors++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL gap_errs got %b%b want 00", parity_err, frame_err); end
        vectors++; if (err_count !== 8'd2) begin errors++; $display("FAIL gap_count got %0d want 2", err_count); end
    endtask

    task automatic test_reset_midframe();
        pulses = 0;
        tick(); in_valid = 1'b1; serial_in = 1'b0;
        tick(); serial_in = 1'b0;
        tick(); serial_in = 1'b0;
        tick(); in_valid = 1'b0; serial_in = 1'b1;
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (busy !== 1'b0 || data_out !== 3'b000 || err_count !== 8'd0) begin
            errors++; $display("FAIL mid_reset got busy=%b data=%b cnt=%0d want 0 000 0", busy, data_out, err_count); end
        send_bits(12'b000111, 6, 0, -1);
        repeat (3) tick();
        vectors++; if (pulses !== 1) begin errors++; $display("FAIL mid_pulses got %0d want 1", pulses); end
        vectors++; if (data_out !== 3'b001) begin errors++; $display("FAIL mid_data got %b want 001", data_out); end
        vectors++; if (err_count !== 8'd0 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL mid_errs got cnt=%0d p=%b f=%b want 0 0 0", err_count, parity_err, frame_err); end
    endtask

    task automatic test_back_to_back();
        pulses = 0;
        send_bits({6'b010101, 6'b011001}, 12, 0, -1);
        repeat (2) tick();
        vectors++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
        vectors++; if (data_out !== 3'b110) begin errors++; $display("FAIL b2b_data got %b want 110", data_out); end
        vectors++; if (err_count !== 8'd0) begin errors++; $display("FAIL b2b_count got %0d want 0", err_count); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 255; k++) send_bits(12'b010001, 6, 0, -1);
        vectors++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_reach got %0d want 255", err_count); end
        send_bits(12'b010001, 6, 0, -1);
        vectors++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", err_count); end
        send_bits(12'b010001, 6, 0, 0);
        vectors++; if (err_count !== 8'd0) begin errors++; $display("FAIL sat_clear got %0d want 0", err_count); end
        vectors++; if (parity_err !== 1'b1) begin errors++; $display("FAIL sat_clear_perr got %b want 1", parity_err); end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_frame_error();
        test_gaps();
        test_reset_midframe();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
